// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache (16 lines x 4 words) with a blocking miss refill.
// One-cycle hit latency. icache_busy stays high from a miss until the refilled line is looked up again.
module inst_cache (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] addr,
  output logic        icache_busy,
  output logic [31:0] inst_rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] vbit_q, vbit_d;
  logic [23:0] tag_q  [16];
  logic [31:0] data_q [16][4];

  logic [23:0] tag_r;
  logic [3:0]  index_r;
  logic [1:0]  offset_r;
  logic        hit;
  logic        refill_wr;
  logic        fill_done;
  logic        unused_addr_lsb;

  assign tag_r    = addr_q[31:8];
  assign index_r  = addr_q[7:4];
  assign offset_r = addr_q[3:2];
  assign hit       = vbit_q[index_r] && (tag_q[index_r] == tag_r);
  assign refill_wr = (state_q == REFILL) && ret_valid;
  assign fill_done = refill_wr && ret_last;
  assign rd_addr   = {tag_r, index_r, 4'b0000};
  // Fetch PCs are word aligned; the byte offset carries no information.
  assign unused_addr_lsb = ^{addr_q[1:0], addr[1:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    vbit_d      = vbit_q;
    icache_busy = 1'b0;
    inst_rdata  = 32'h0;
    rd_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          addr_d  = addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          inst_rdata = data_q[index_r][offset_r];
          if (valid) begin
            addr_d = addr;
          end else begin
            state_d = IDLE;
          end
        end else begin
          icache_busy = 1'b1;
          state_d     = MISS;
        end
      end
      MISS: begin
        icache_busy = 1'b1;
        rd_req      = 1'b1;
        if (rd_rdy) begin
          cnt_d   = 2'd0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        icache_busy = 1'b1;
        if (refill_wr) begin
          cnt_d = cnt_q + 2'd1;
        end
        // A short burst ends here too; words never written keep their old contents.
        if (fill_done) begin
          vbit_d[index_r] = 1'b1;
          state_d         = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      cnt_q   <= 2'd0;
      vbit_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vbit_q  <= vbit_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_q[index_r][cnt_q] <= ret_data;
    end
    if (fill_done) begin
      tag_q[index_r] <= tag_r;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized and directed bench for inst_cache against a line-level cache model.
module tb_inst_cache;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] addr;
  logic        icache_busy;
  logic [31:0] inst_rdata;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each line of the cache is supposed to hold.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];
  bit          m_known [16][4];

  inst_cache dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid      (valid),
    .addr       (addr),
    .icache_busy(icache_busy),
    .inst_rdata (inst_rdata),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_rdy     (rd_rdy),
    .ret_valid  (ret_valid),
    .ret_last   (ret_last),
    .ret_data   (ret_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  // Checks a lookup cycle that the model says must hit.
  task automatic chk_hit_data(input string tag, input logic [31:0] a);
    chk({tag, "_busy"}, {31'b0, icache_busy}, 32'h0);
    if (m_known[a[7:4]][a[3:2]]) chk({tag, "_data"}, inst_rdata, m_data[a[7:4]][a[3:2]]);
  endtask

  // One fetch from idle. On a miss: k cycles of rd_rdy low, then n beats (n<4 = short burst).
  // abort_after > 0 pulls reset after that many beats.
  task automatic fetch(input logic [31:0] a, input int k, input int n,
                       input logic [3:0][31:0] d, input int abort_after);
    logic [3:0]  idx;
    bit          hit;
    idx = a[7:4];
    hit = model_hit(a);
    @(posedge clk); #1;
    valid = 1'b1; addr = a;
    @(posedge clk); #1;
    valid = 1'b0; addr = $urandom;
    @(negedge clk);
    if (hit) begin
      chk_hit_data("lookup_hit", a);
      return;
    end
    chk("lookup_miss_busy", {31'b0, icache_busy}, 32'h1);
    chk("lookup_miss_rdata", inst_rdata, 32'h0);
    chk("lookup_miss_rdreq", {31'b0, rd_req}, 32'h0);
    for (int c = 0; c <= k; c++) begin
      @(posedge clk); #1;
      rd_rdy    = (c == k);
      valid     = 1'($urandom);
      addr      = $urandom;
      ret_valid = 1'($urandom);
      ret_last  = 1'($urandom);
      ret_data  = $urandom;
      @(negedge clk);
      chk("miss_rdreq", {31'b0, rd_req}, 32'h1);
      chk("miss_rdaddr", rd_addr, {a[31:4], 4'b0000});
      chk("miss_busy", {31'b0, icache_busy}, 32'h1);
    end
    @(posedge clk); #1;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 2)) begin
        valid = 1'($urandom); addr = $urandom;
        @(negedge clk);
        chk("refill_gap_busy", {31'b0, icache_busy}, 32'h1);
        chk("refill_gap_rdreq", {31'b0, rd_req}, 32'h0);
        @(posedge clk); #1;
      end
      ret_valid = 1'b1; ret_data = d[b]; ret_last = (b == n - 1);
      valid = 1'($urandom); addr = $urandom;
      @(negedge clk);
      chk("refill_busy", {31'b0, icache_busy}, 32'h1);
      chk("refill_rdata", inst_rdata, 32'h0);
      @(posedge clk);
      m_data[idx][b]  = d[b];
      m_known[idx][b] = 1'b1;
      #1;
      ret_valid = 1'b0; ret_last = 1'b0; valid = 1'b0;
      if (abort_after == b + 1) begin
        resetn = 1'b0;
        model_reset();
        #2;
        chk("rst_busy", {31'b0, icache_busy}, 32'h0);
        chk("rst_rdreq", {31'b0, rd_req}, 32'h0);
        chk("rst_rdaddr", rd_addr, 32'h0);
        chk("rst_rdata", inst_rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_busy", {31'b0, icache_busy}, 32'h0);
        return;
      end
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[31:8];
    @(negedge clk);
    chk_hit_data("relookup", a);
  endtask

  // Back-to-back fetches, all expected to hit; valid held high across consecutive cycles.
  task automatic stream(input logic [31:0] a0, input int n);
    logic [31:0] prev;
    prev = a0;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i < n) begin
        valid = 1'b1; addr = a0 + 32'(4 * i);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) chk_hit_data("stream", prev);
      prev = a0 + 32'(4 * i);
    end
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [31:0]      tags [3];
    logic [31:0]      a;
    tags[0] = 32'hBFC000; tags[1] = 32'h9FC000; tags[2] = 32'h000001;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) m_known[i][j] = 1'b0;
    model_reset();
    resetn = 1'b0; valid = 1'b0; addr = 32'h0; rd_rdy = 1'b0;
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    #3;
    chk("reset_busy", {31'b0, icache_busy}, 32'h0);
    chk("reset_rdata", inst_rdata, 32'h0);
    chk("reset_rdreq", {31'b0, rd_req}, 32'h0);
    chk("reset_rdaddr", rd_addr, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Cold miss, then streaming hits through the same line.
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    fetch(32'hBFC00000, 0, 4, d, 0);
    chk("cold_relookup_word0", inst_rdata, 32'h11);
    stream(32'hBFC00004, 3);

    // Conflict eviction on index 0.
    d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    fetch(32'h9FC00000, 1, 4, d, 0);
    chk("evict_new_line_word0", inst_rdata, 32'hA0);
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    fetch(32'hBFC00000, 5, 4, d, 0);

    // Short burst on index 1: two words written, line becomes valid.
    d = {32'h0, 32'h0, 32'hB1, 32'hB0};
    fetch(32'hBFC00114, 2, 2, d, 0);
    chk("short_word1", inst_rdata, 32'hB1);
    fetch(32'hBFC00110, 0, 4, d, 0);
    chk("short_word0_hit", inst_rdata, 32'hB0);

    // Reset in the middle of a refill, then the same address must miss again.
    d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    fetch(32'h9FC00020, 1, 4, d, 2);
    fetch(32'h9FC00020, 0, 4, d, 0);
    chk("after_abort_refetch", inst_rdata, 32'hC0);

    // Randomized traffic over a small address set so hits and conflicts both happen.
    for (int t = 0; t < 80; t++) begin
      a = {tags[$urandom_range(0, 2)][23:0], 4'($urandom_range(0, 3)), 2'($urandom), 2'b00};
      for (int w = 0; w < 4; w++) d[w] = $urandom;
      if ($urandom_range(0, 5) == 0 && model_hit({a[31:4], 4'b0}))
        stream({a[31:4], 4'b0}, 4);
      else
        fetch(a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4, d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 The block SHALL have these ports, in this order: clk, resetn, valid, addr, icache_busy, inst_rdata, rd_req, rd_addr, rd_rdy, ret_valid, ret_last, ret_data.
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  fetch request; asserted when the pre-fetch stage hands a PC to the fetch stage.
- addr  in  32  fetch PC, word aligned; sampled when valid is accepted.
- icache_busy  out  1  high while the pending fetch cannot return an instruction this cycle.
- inst_rdata  out  32  instruction for the pending fetch; meaningful only while the block is in LOOKUP, a hit occurs and icache_busy is low.
- rd_req  out  1  line refill request to memory.
- rd_addr  out  32  refill address: {tag, index, 4'b0000}.
- rd_rdy  in  1  memory accepts rd_req this cycle.
- ret_valid  in  1  one refill data beat valid.
- ret_last  in  1  final refill beat.
- ret_data  in  32  refill data beat.

Function
REQ-002 The organisation SHALL be direct-mapped: 16 lines of 4 words.
REQ-003 Address fields SHALL be: offset = addr[3:2], index = addr[7:4], tag = addr[31:8].
REQ-004 Per line, the block SHALL store a valid bit, a 24-bit tag and 4x32-bit data; tag and data reads SHALL be combinational.
REQ-005 The block SHALL hold a request register (addr_r) and a 2-bit state: IDLE, LOOKUP, MISS, REFILL.
REQ-006 IDLE: icache_busy=0; inst_rdata=0. If valid=1, the block SHALL latch addr into addr_r and go to LOOKUP.
REQ-007 A hit SHALL be defined as valid_bit[index_r] & (tag[index_r] == tag_r).
REQ-008 LOOKUP with a hit: icache_busy=0 and inst_rdata = data[index_r][offset_r] in the same cycle (one-cycle hit latency after acceptance).
- If valid=1 that cycle, the block SHALL latch the new addr and stay in LOOKUP (back-to-back fetches, one per cycle).
- Otherwise the block SHALL go to IDLE.
REQ-009 LOOKUP with a miss: icache_busy=1, inst_rdata=0; next state MISS; valid SHALL be ignored.
REQ-010 MISS: rd_req=1 and rd_addr={tag_r, index_r, 4'b0}; both SHALL be held stable until rd_rdy=1, then the block SHALL go to REFILL with the beat counter cleared.
REQ-011 REFILL: each ret_valid beat SHALL write ret_data into data[index_r][cnt], and cnt SHALL increment, wrapping modulo 4.
REQ-012 On the beat with ret_valid & ret_last, the block SHALL write that beat, set valid_bit[index_r]=1 and tag[index_r]=tag_r, then go to LOOKUP.
- The re-lookup in the following cycle SHALL hit.
REQ-013 If ret_last arrives before 4 beats, the refill SHALL still terminate; unwritten words keep their old contents.
REQ-014 In MISS and REFILL: icache_busy=1, inst_rdata=0, and valid SHALL be ignored.
REQ-015 rd_req SHALL be 0 in every state other than MISS.
REQ-016 Miss latency from acceptance SHALL be: 1 (LOOKUP) + handshake wait + beat count + 1 (re-lookup) cycles.
REQ-017 A refill SHALL overwrite the line at index_r without regard to its previous tag (no write-back; the cache is read-only).
REQ-018 ret_valid outside REFILL SHALL be ignored.

Reset
REQ-019 While resetn=0, asynchronously: state=IDLE, all 16 valid bits=0, addr_r=0, cnt=0.
REQ-020 Outputs during reset: icache_busy=0, inst_rdata=0, rd_req=0, rd_addr=0.
REQ-021 Tag and data arrays SHALL NOT require reset.
REQ-022 Reset asserted mid-refill SHALL abandon the refill; the target line SHALL remain invalid after reset release.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Cold miss: after reset, valid=1, addr=0xBFC00000 -> LOOKUP miss, busy=1; rd_req=1, rd_addr=0xBFC00000 held until rd_rdy; 4 beats 0x11,0x22,0x33,0x44 (last on 4th) -> next cycle busy=0, inst_rdata=0x11.
- Streaming hits: after the line fill, valid=1 on consecutive cycles with addr 0xBFC00004, 0xBFC00008, 0xBFC0000C -> busy=0 and inst_rdata 0x22, 0x33, 0x44 on consecutive cycles.
- Conflict eviction: fetch 0x9FC00000 (same index 0, new tag) -> miss; refill with 0xA0..0xA3; re-fetch 0xBFC00000 -> miss again (line evicted).
- Delayed handshake: rd_rdy held low 5 cycles -> rd_req/rd_addr stable for 6 cycles, busy=1, valid pulses ignored.
- Short burst: ret_last on beat 2 -> words 0–1 written, line valid, state LOOKUP next cycle.
- Reset mid-REFILL after 2 beats -> state IDLE, rd_req=0; re-fetch of the same address -> miss.
